// File: rtl/cmos_pkg.sv
// Shared types and constants for the camera capture path and its timing generator.
// Holds the capture FSM encoding, default video geometry and bytes-per-pixel limits.
package cmos_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

    // Default 640x480 geometry, shared with the simulation timing generator
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int BPP_MIN      = 1;
    localparam int BPP_MAX      = 3;
    localparam int PIX_W        = 24;
    localparam int COORD_W      = 11;
    localparam int LINE_BYTES_W = 13;

    function automatic logic [COORD_W-1:0] sat_inc_coord(input logic [COORD_W-1:0] v);
        return (v == 11'd2047) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/cmos_byte_packer.sv
// Collects BPP consecutive bytes into one right-aligned pixel word and raises a
// registered one-cycle strobe when the last byte of a kept pixel is sampled.
module cmos_byte_packer
    import cmos_pkg::*;
#(
    parameter int BPP    = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_en,
    input  logic              clear,
    input  logic              keep,
    input  logic [DATA_W-1:0] data,
    output logic              last_byte,
    output logic              pix_strobe,
    output logic [PIX_W-1:0]  pix_word
);

    localparam int CNT_W = 2;
    localparam logic [PIX_W-1:0] PIX_MASK = PIX_W'((64'd1 << (BPP * DATA_W)) - 64'd1);

    logic [CNT_W-1:0] byte_cnt_r;
    logic [PIX_W-1:0] shift_r;
    logic [PIX_W-1:0] shift_next_s;
    logic             pix_strobe_r;
    logic [PIX_W-1:0] pix_word_r;
    logic             last_byte_s;

    // Older bytes fall off the top through the mask, so byte 0 needs no explicit clear
    always_comb begin
        shift_next_s = ((shift_r << DATA_W) | PIX_W'(data)) & PIX_MASK;
        last_byte_s  = byte_en && (byte_cnt_r == CNT_W'(BPP - 1));
    end

    // Byte counter, shift register and registered pixel strobe/word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r   <= 2'd0;
            shift_r      <= 24'd0;
            pix_strobe_r <= 1'b0;
            pix_word_r   <= 24'd0;
        end else begin
            pix_strobe_r <= last_byte_s && keep;
            if (clear) begin
                byte_cnt_r <= 2'd0;
                shift_r    <= 24'd0;
            end else if (byte_en) begin
                shift_r <= shift_next_s;
                if (last_byte_s) begin
                    byte_cnt_r <= 2'd0;
                    if (keep) begin
                        pix_word_r <= shift_next_s;
                    end
                end else begin
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                end
            end
        end
    end

    assign last_byte  = last_byte_s;
    assign pix_strobe = pix_strobe_r;
    assign pix_word   = pix_word_r;

endmodule

// File: rtl/cmos_capture.sv
// Camera receive front end: frames vsync/href/byte stream into pixels with x/y
// coordinates and a linear address, and flags line and frame geometry errors.
module cmos_capture
    import cmos_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   BPP        = 3,
    parameter int   DATA_W     = 8,
    parameter logic VS_POL     = 1'b0,
    parameter int   FRAME_SKIP = 0,
    parameter int   ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmos_vsync,
    input  logic              cmos_href,
    input  logic [DATA_W-1:0] cmos_data,
    output logic              pix_valid,
    output logic [23:0]       pix_data,
    output logic [10:0]       pix_x,
    output logic [10:0]       pix_y,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err
);

    cap_state_e state_r;
    cap_state_e state_next_s;

    logic sync_act_s, sync_act_r, href_r;
    logic sync_rise_s, sync_fall_s, href_fall_s;
    logic in_capture_s, frame_begin_s, frame_end_s, line_end_s, byte_en_s;
    logic line_has_bytes_s, keep_s, last_byte_s, packer_clear_s;

    logic [COORD_W-1:0]      x_cnt_r, y_cnt_r, lines_done_s;
    logic [ADDR_W-1:0]       addr_cnt_r, row_base_r;
    logic [LINE_BYTES_W-1:0] line_bytes_r;
    logic [3:0]              frame_cnt_r;
    logic                    skip_r;

    logic [COORD_W-1:0] pix_x_r, pix_y_r;
    logic [ADDR_W-1:0]  pix_addr_r;
    logic               frame_start_r, frame_done_r, line_err_r, frame_err_r;

    // Edge detection against the once-registered sync/href levels
    always_comb begin
        sync_act_s       = (cmos_vsync == VS_POL);
        sync_rise_s      = sync_act_s && !sync_act_r;
        sync_fall_s      = !sync_act_s && sync_act_r;
        href_fall_s      = href_r && !cmos_href;
        in_capture_s     = (state_r == CAPTURE);
        frame_begin_s    = (state_r == SYNC) && sync_fall_s;
        frame_end_s      = in_capture_s && sync_rise_s;
        line_end_s       = in_capture_s && href_fall_s;
        byte_en_s        = in_capture_s && cmos_href;
        packer_clear_s   = !in_capture_s || href_fall_s;
        line_has_bytes_s = (line_bytes_r != 13'd0);
        keep_s           = !skip_r && (32'(x_cnt_r) < H_ACTIVE) && (32'(y_cnt_r) < V_ACTIVE);
        // A line ending on the same edge as the frame must still be counted
        lines_done_s     = (line_end_s && line_has_bytes_s) ? sat_inc_coord(y_cnt_r) : y_cnt_r;
    end

    // Input level history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_act_r <= 1'b0;
            href_r     <= 1'b0;
        end else begin
            sync_act_r <= sync_act_s;
            href_r     <= cmos_href;
        end
    end

    // Capture FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (sync_act_s) state_next_s = SYNC;
                else            state_next_s = IDLE;
            end
            SYNC: begin
                if (sync_fall_s) state_next_s = CAPTURE;
                else             state_next_s = SYNC;
            end
            CAPTURE: begin
                if (sync_rise_s) state_next_s = SYNC;
                else             state_next_s = CAPTURE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Geometry counters, output coordinates and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_r       <= 11'd0;
            y_cnt_r       <= 11'd0;
            addr_cnt_r    <= '0;
            row_base_r    <= '0;
            line_bytes_r  <= 13'd0;
            frame_cnt_r   <= 4'd0;
            skip_r        <= 1'b0;
            pix_x_r       <= 11'd0;
            pix_y_r       <= 11'd0;
            pix_addr_r    <= '0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            line_err_r    <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            line_err_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            if (frame_begin_s) begin
                x_cnt_r      <= 11'd0;
                y_cnt_r      <= 11'd0;
                addr_cnt_r   <= '0;
                row_base_r   <= '0;
                line_bytes_r <= 13'd0;
                if (32'(frame_cnt_r) < FRAME_SKIP) begin
                    frame_cnt_r <= frame_cnt_r + 4'd1;
                    skip_r      <= 1'b1;
                end else begin
                    skip_r        <= 1'b0;
                    frame_start_r <= 1'b1;
                end
            end else if (in_capture_s) begin
                if (line_end_s) begin
                    line_err_r   <= (32'(line_bytes_r) != H_ACTIVE * BPP);
                    line_bytes_r <= 13'd0;
                    if (line_has_bytes_s) begin
                        // Row base advances by H_ACTIVE per line instead of multiplying y
                        y_cnt_r    <= lines_done_s;
                        x_cnt_r    <= 11'd0;
                        row_base_r <= row_base_r + ADDR_W'(H_ACTIVE);
                        addr_cnt_r <= row_base_r + ADDR_W'(H_ACTIVE);
                    end
                end else if (byte_en_s) begin
                    line_bytes_r <= (line_bytes_r == 13'h1FFF) ? line_bytes_r : line_bytes_r + 13'd1;
                    if (last_byte_s) begin
                        x_cnt_r    <= sat_inc_coord(x_cnt_r);
                        addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
                        if (keep_s) begin
                            pix_x_r    <= x_cnt_r;
                            pix_y_r    <= y_cnt_r;
                            pix_addr_r <= addr_cnt_r;
                        end
                    end
                end
                if (frame_end_s) begin
                    frame_done_r <= !skip_r;
                    frame_err_r  <= !skip_r && (32'(lines_done_s) != V_ACTIVE);
                end
            end
        end
    end

    cmos_byte_packer #(
        .BPP    (BPP),
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_en    (byte_en_s),
        .clear      (packer_clear_s),
        .keep       (keep_s),
        .data       (cmos_data),
        .last_byte  (last_byte_s),
        .pix_strobe (pix_valid),
        .pix_word   (pix_data)
    );

    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign pix_addr    = pix_addr_r;
    assign frame_start = frame_start_r;
    assign frame_done  = frame_done_r;
    assign line_err    = line_err_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_cmos_capture.sv
// Bench for cmos_capture: three instances (BPP=3, BPP=3 with one skipped frame,
// BPP=2 with inverted vsync polarity) share one stimulus stream and a frame-level model.
module tb_cmos_capture;

    localparam int H = 4;
    localparam int V = 3;
    localparam int BPP_T  [3] = '{3, 3, 2};
    localparam int SKIP_T [3] = '{0, 1, 0};

    typedef struct {
        logic [23:0] data;
        int          x;
        int          y;
        int          addr;
        int          cyc;
    } pix_t;

    typedef struct {
        int nl;
        int len [5];
        int mode;
        int e_pix;
        int e_le;
        int e_fe;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       vsync, vsync_b, href;
    logic [7:0] cmos_data;

    logic [2:0]  pv, fs_o, fd_o, le_o, fe_o;
    logic [23:0] pd [3];
    logic [10:0] px [3];
    logic [10:0] py [3];
    logic [18:0] pa [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int seq   = 0;

    pix_t exp_q0[$], exp_q1[$], exp_q2[$];

    bit sync_lvl  = 1'b0;
    bit armed     = 1'b0;
    bit capturing = 1'b0;
    int fidx [3]  = '{0, 0, 0};
    bit skipped [3];
    int row  [3]  = '{0, 0, 0};
    int exp_fs [3] = '{0, 0, 0};
    int exp_fd [3] = '{0, 0, 0};
    int exp_fe [3] = '{0, 0, 0};
    int exp_le [3] = '{0, 0, 0};
    int act_fs [3] = '{0, 0, 0};
    int act_fd [3] = '{0, 0, 0};
    int act_fe [3] = '{0, 0, 0};
    int act_le [3] = '{0, 0, 0};
    int act_pix[3] = '{0, 0, 0};

    cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(3), .VS_POL(1'b0), .FRAME_SKIP(0)) u_n (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(cmos_data),
        .pix_valid(pv[0]), .pix_data(pd[0]), .pix_x(px[0]), .pix_y(py[0]), .pix_addr(pa[0]),
        .frame_start(fs_o[0]), .frame_done(fd_o[0]), .line_err(le_o[0]), .frame_err(fe_o[0]));

    cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(3), .VS_POL(1'b0), .FRAME_SKIP(1)) u_s (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(cmos_data),
        .pix_valid(pv[1]), .pix_data(pd[1]), .pix_x(px[1]), .pix_y(py[1]), .pix_addr(pa[1]),
        .frame_start(fs_o[1]), .frame_done(fd_o[1]), .line_err(le_o[1]), .frame_err(fe_o[1]));

    cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(2), .VS_POL(1'b1), .FRAME_SKIP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(vsync_b), .cmos_href(href), .cmos_data(cmos_data),
        .pix_valid(pv[2]), .pix_data(pd[2]), .pix_x(px[2]), .pix_y(py[2]), .pix_addr(pa[2]),
        .frame_start(fs_o[2]), .frame_done(fd_o[2]), .line_err(le_o[2]), .frame_err(fe_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic pix_t qpop(input int d);
        case (d)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int d, input pix_t p);
        case (d)
            0:       exp_q0.push_back(p);
            1:       exp_q1.push_back(p);
            default: exp_q2.push_back(p);
        endcase
    endfunction

    // Output monitor: every strobe is matched against the next expected pixel
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (fs_o[d]) act_fs[d]++;
            if (fd_o[d]) act_fd[d]++;
            if (le_o[d]) act_le[d]++;
            if (fe_o[d]) begin
                act_fe[d]++;
                chk($sformatf("dut%0d_frame_err_with_done", d), 64'(fd_o[d]), 64'd1);
            end
            if (pv[d] === 1'b1) begin
                act_pix[d]++;
                if (qsize(d) == 0) begin
                    chk($sformatf("dut%0d_unexpected_pix", d), 64'd1, 64'd0);
                end else begin
                    pix_t p;
                    p = qpop(d);
                    chk($sformatf("dut%0d_pix_data", d), 64'(pd[d]), 64'(p.data));
                    chk($sformatf("dut%0d_pix_x", d),    64'(px[d]), 64'(p.x));
                    chk($sformatf("dut%0d_pix_y", d),    64'(py[d]), 64'(p.y));
                    chk($sformatf("dut%0d_pix_addr", d), 64'(pa[d]), 64'(p.addr));
                    chk($sformatf("dut%0d_pix_latency", d), 64'(cyc), 64'(p.cyc));
                end
            end
        end
    end

    // Sync level change; the model follows the frame rules on each transition
    task automatic set_sync(input bit act);
        if (act && !sync_lvl) begin
            if (capturing) begin
                for (int d = 0; d < 3; d++) begin
                    if (!skipped[d]) begin
                        exp_fd[d]++;
                        if (row[d] != V) exp_fe[d]++;
                    end
                end
            end
            capturing = 1'b0;
            armed     = 1'b1;
        end else if (!act && sync_lvl && armed) begin
            for (int d = 0; d < 3; d++) begin
                skipped[d] = (fidx[d] < SKIP_T[d]);
                if (!skipped[d]) exp_fs[d]++;
                fidx[d]++;
                row[d] = 0;
            end
            capturing = 1'b1;
            armed     = 1'b0;
        end
        sync_lvl = act;
        vsync    = act ? 1'b0 : 1'b1;
        vsync_b  = ~vsync;
    endtask

    task automatic drive_line(input int len, input int mode, input bit abort);
        logic [7:0]  lb[$];
        logic [7:0]  b;
        logic [23:0] v;
        pix_t        p;
        int          x;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            case (mode)
                0:       begin b = 8'(seq); seq++; end
                1:       b = 8'($urandom_range(0, 255));
                default: b = (i % 2 == 0) ? 8'hF8 : 8'h1F;
            endcase
            cmos_data = b;
            href      = 1'b1;
            lb.push_back(b);
            if (capturing) begin
                for (int d = 0; d < 3; d++) begin
                    if ((i + 1) % BPP_T[d] == 0) begin
                        x = (i + 1) / BPP_T[d] - 1;
                        v = 24'd0;
                        for (int j = i - BPP_T[d] + 1; j <= i; j++) v = {v[15:0], lb[j]};
                        if (!skipped[d] && x < H && row[d] < V) begin
                            p.data = v;
                            p.x    = x;
                            p.y    = row[d];
                            p.addr = row[d] * H + x;
                            p.cyc  = cyc + 1;
                            qpush(d, p);
                        end
                    end
                end
            end
        end
        if (!abort) begin
            @(negedge clk);
            href      = 1'b0;
            cmos_data = 8'd0;
            if (capturing) begin
                for (int d = 0; d < 3; d++) begin
                    if (len != H * BPP_T[d]) exp_le[d]++;
                    if (len > 0) row[d]++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input int nl, input int lens [5], input int mode);
        set_sync(1'b1);
        repeat (3) @(negedge clk);
        set_sync(1'b0);
        seq = 0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < nl; l++) drive_line(lens[l], mode, 1'b0);
        repeat (2) @(negedge clk);
        set_sync(1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_check(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_dut%0d_frame_start", tag, d), 64'(act_fs[d]), 64'(exp_fs[d]));
            chk($sformatf("%s_dut%0d_frame_done", tag, d),  64'(act_fd[d]), 64'(exp_fd[d]));
            chk($sformatf("%s_dut%0d_frame_err", tag, d),   64'(act_fe[d]), 64'(exp_fe[d]));
            chk($sformatf("%s_dut%0d_line_err", tag, d),    64'(act_le[d]), 64'(exp_le[d]));
            chk($sformatf("%s_dut%0d_missing_pix", tag, d), 64'(qsize(d)),  64'd0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_dut%0d_pix_valid", tag, d),   64'(pv[d]),   64'd0);
            chk($sformatf("%s_dut%0d_pix_data", tag, d),    64'(pd[d]),   64'd0);
            chk($sformatf("%s_dut%0d_pix_x", tag, d),       64'(px[d]),   64'd0);
            chk($sformatf("%s_dut%0d_pix_y", tag, d),       64'(py[d]),   64'd0);
            chk($sformatf("%s_dut%0d_pix_addr", tag, d),    64'(pa[d]),   64'd0);
            chk($sformatf("%s_dut%0d_frame_start", tag, d), 64'(fs_o[d]), 64'd0);
            chk($sformatf("%s_dut%0d_frame_done", tag, d),  64'(fd_o[d]), 64'd0);
            chk($sformatf("%s_dut%0d_line_err", tag, d),    64'(le_o[d]), 64'd0);
            chk($sformatf("%s_dut%0d_frame_err", tag, d),   64'(fe_o[d]), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [7];
        int   p0, le0, fe0, fs0, fd0, le1;
        int   rl [5];

        // Expected counts below are for the BPP=3, no-skip instance
        tbl[0] = '{nl: 3, len: '{12, 12, 12, 0, 0}, mode: 0, e_pix: 12, e_le: 0, e_fe: 0};
        tbl[1] = '{nl: 3, len: '{12, 12, 12, 0, 0}, mode: 0, e_pix: 12, e_le: 0, e_fe: 0};
        tbl[2] = '{nl: 3, len: '{12, 11, 12, 0, 0}, mode: 0, e_pix: 11, e_le: 1, e_fe: 0};
        tbl[3] = '{nl: 4, len: '{12, 12, 12, 12, 0}, mode: 0, e_pix: 12, e_le: 0, e_fe: 1};
        tbl[4] = '{nl: 3, len: '{12, 15, 12, 0, 0}, mode: 1, e_pix: 12, e_le: 1, e_fe: 0};
        tbl[5] = '{nl: 2, len: '{12, 12, 0, 0, 0}, mode: 1, e_pix: 8, e_le: 0, e_fe: 1};
        tbl[6] = '{nl: 3, len: '{12, 12, 12, 0, 0}, mode: 2, e_pix: 12, e_le: 0, e_fe: 0};

        rst_n     = 1'b0;
        href      = 1'b0;
        cmos_data = 8'd0;
        vsync     = 1'b1;
        vsync_b   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 7; r++) begin
            p0  = act_pix[0];
            le0 = act_le[0];
            fe0 = act_fe[0];
            fs0 = act_fs[0];
            fd0 = act_fd[0];
            run_frame(tbl[r].nl, tbl[r].len, tbl[r].mode);
            chk($sformatf("row%0d_pix_count", r),   64'(act_pix[0] - p0), 64'(tbl[r].e_pix));
            chk($sformatf("row%0d_line_err", r),    64'(act_le[0] - le0), 64'(tbl[r].e_le));
            chk($sformatf("row%0d_frame_err", r),   64'(act_fe[0] - fe0), 64'(tbl[r].e_fe));
            chk($sformatf("row%0d_frame_start", r), 64'(act_fs[0] - fs0), 64'd1);
            chk($sformatf("row%0d_frame_done", r),  64'(act_fd[0] - fd0), 64'd1);
            if (r == 0) begin
                chk("skip_first_frame_pix", 64'(act_pix[1]), 64'd0);
                chk("skip_first_frame_fs",  64'(act_fs[1]),  64'd0);
            end
            frame_check($sformatf("row%0d", r));
        end

        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = int'($urandom_range(2, 4));
            for (int l = 0; l < 5; l++) rl[l] = int'($urandom_range(9, 14));
            run_frame(nl, rl, 1);
            frame_check($sformatf("rand%0d", f));
        end

        // Reset in the middle of the second line of a frame
        set_sync(1'b1);
        repeat (3) @(negedge clk);
        set_sync(1'b0);
        seq = 0;
        repeat (2) @(negedge clk);
        drive_line(12, 0, 1'b0);
        drive_line(5, 0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        href  = 1'b0;
        set_sync(1'b0);
        capturing = 1'b0;
        armed     = 1'b0;
        for (int d = 0; d < 3; d++) fidx[d] = 0;
        #1;
        check_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        p0 = act_pix[0];
        drive_line(12, 0, 1'b0);
        chk("idle_line_ignored_pix", 64'(act_pix[0] - p0), 64'd0);
        le1 = act_le[1];
        p0  = act_pix[0];
        run_frame(3, '{12, 11, 12, 0, 0}, 0);
        chk("post_reset_pix_count",     64'(act_pix[0] - p0), 64'd11);
        chk("post_reset_skip_line_err", 64'(act_le[1] - le1), 64'd1);
        frame_check("postreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
